// File: rtl/shift_sequencer_if.sv
// ----------------------------------------------------------------------------
// shift_sequencer_if
// Bundles the request, shifter and response signals of the shift sequencer.
//   req_valid/req_ready     : per-port request handshake (bit0 = port 0)
//   req_data*/amt*/left*    : per-port operand, amount (0-31), direction
//   sh_string/amount/left   : drive to the shared barrel shifter
//   sh_result               : combinational result back from the shifter
//   rsp_valid/ready/data/id : response handshake, result and issuing port
//   busy                    : sequencer is not idle
// Modports: slave = sequencer side, master = requesters/shifter/consumer side.
// ----------------------------------------------------------------------------
interface shift_sequencer_if #(
   parameter int WIDTH = 16,
   parameter int SW    = 4,
   parameter int AW    = 5
);
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [WIDTH-1:0] req_data0;
   logic [WIDTH-1:0] req_data1;
   logic [AW-1:0]    req_amt0;
   logic [AW-1:0]    req_amt1;
   logic             req_left0;
   logic             req_left1;
   logic [WIDTH-1:0] sh_string;
   logic [SW-1:0]    sh_amount;
   logic             sh_left;
   logic [WIDTH-1:0] sh_result;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_id;
   logic             busy;

   modport slave (
      input  req_valid, req_data0, req_data1, req_amt0, req_amt1,
             req_left0, req_left1, sh_result, rsp_ready,
      output req_ready, sh_string, sh_amount, sh_left,
             rsp_valid, rsp_data, rsp_id, busy
   );

   modport master (
      output req_valid, req_data0, req_data1, req_amt0, req_amt1,
             req_left0, req_left1, sh_result, rsp_ready,
      input  req_ready, sh_string, sh_amount, sh_left,
             rsp_valid, rsp_data, rsp_id, busy
   );
endinterface

// File: rtl/shift_sequencer.sv
// ----------------------------------------------------------------------------
// shift_sequencer
// Round-robin arbiter and multi-pass controller for a shared barrel shifter
// that moves at most 2**SW-1 positions per pass. A request of 0..2**AW-1
// positions is split into passes of min(remaining, 2**SW-1); the final
// result is returned with a valid/ready handshake.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : shift_sequencer_if.slave (requests, shifter drive, response)
// ----------------------------------------------------------------------------
module shift_sequencer #(
   parameter int WIDTH = 16,
   parameter int SW    = 4,
   parameter int AW    = 5
) (
   input logic              clk,
   input logic              rst,
   shift_sequencer_if.slave bus
);

   localparam int MAX_STEP = (2 ** SW) - 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PASS = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   logic [AW-1:0]    rem_r;
   logic             id_r;
   logic             last_grant_r;
   logic [WIDTH-1:0] sh_string_r;
   logic [SW-1:0]    sh_amount_r;
   logic             sh_left_r;
   logic             rsp_valid_r;
   logic [WIDTH-1:0] rsp_data_r;
   logic             rsp_id_r;
   logic             busy_r;

   logic             grant_valid_s;
   logic             grant_s;
   logic             xfer_s;
   logic [1:0]       req_ready_s;
   logic [WIDTH-1:0] sel_data_s;
   logic [AW-1:0]    sel_amt_s;
   logic             sel_left_s;
   logic [SW-1:0]    step_s;
   logic [AW-1:0]    rem_next_s;

   // Largest amount the shifter can take in one pass.
   function automatic logic [SW-1:0] clamp_step(input logic [AW-1:0] amt);
      if (amt > AW'(MAX_STEP)) begin
         return SW'(MAX_STEP);
      end else begin
         return amt[SW-1:0];
      end
   endfunction

   // Round-robin grant: a lone requester wins, a tie goes to the port not served last.
   always_comb begin
      grant_valid_s = 1'b0;
      grant_s       = 1'b0;
      case (bus.req_valid)
         2'b01: begin
            grant_valid_s = 1'b1;
            grant_s       = 1'b0;
         end
         2'b10: begin
            grant_valid_s = 1'b1;
            grant_s       = 1'b1;
         end
         2'b11: begin
            grant_valid_s = 1'b1;
            grant_s       = ~last_grant_r;
         end
         default: begin
            grant_valid_s = 1'b0;
            grant_s       = 1'b0;
         end
      endcase
   end

   // Accept only in IDLE; req_ready is the one combinational output by design.
   always_comb begin
      xfer_s      = 1'b0;
      req_ready_s = 2'b00;
      if ((state_r == IDLE) && grant_valid_s) begin
         xfer_s      = 1'b1;
         req_ready_s = grant_s ? 2'b10 : 2'b01;
      end else begin
         xfer_s      = 1'b0;
         req_ready_s = 2'b00;
      end
   end

   // Operand of the granted port.
   always_comb begin
      sel_data_s = bus.req_data0;
      sel_amt_s  = bus.req_amt0;
      sel_left_s = bus.req_left0;
      if (grant_s) begin
         sel_data_s = bus.req_data1;
         sel_amt_s  = bus.req_amt1;
         sel_left_s = bus.req_left1;
      end else begin
         sel_data_s = bus.req_data0;
         sel_amt_s  = bus.req_amt0;
         sel_left_s = bus.req_left0;
      end
   end

   // Per-pass step and what remains after it.
   always_comb begin
      step_s     = clamp_step(rem_r);
      rem_next_s = rem_r - AW'(step_s);
   end

   // Sequencer FSM; the working operand lives in sh_string_r while passes run.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         rem_r        <= '0;
         id_r         <= 1'b0;
         last_grant_r <= 1'b1;
         sh_string_r  <= '0;
         sh_amount_r  <= '0;
         sh_left_r    <= 1'b0;
         rsp_valid_r  <= 1'b0;
         rsp_data_r   <= '0;
         rsp_id_r     <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (xfer_s) begin
                  rem_r        <= sel_amt_s;
                  id_r         <= grant_s;
                  last_grant_r <= grant_s;
                  sh_string_r  <= sel_data_s;
                  sh_amount_r  <= clamp_step(sel_amt_s);
                  sh_left_r    <= sel_left_s;
                  busy_r       <= 1'b1;
                  state_r      <= PASS;
               end
            end
            PASS: begin
               rem_r <= rem_next_s;
               if (rem_next_s == '0) begin
                  // Last pass: capture the result and park the shifter drive at 0.
                  rsp_valid_r <= 1'b1;
                  rsp_data_r  <= bus.sh_result;
                  rsp_id_r    <= id_r;
                  sh_string_r <= '0;
                  sh_amount_r <= '0;
                  sh_left_r   <= 1'b0;
                  state_r     <= DONE;
               end else begin
                  sh_string_r <= bus.sh_result;
                  sh_amount_r <= clamp_step(rem_next_s);
               end
            end
            DONE: begin
               if (bus.rsp_ready) begin
                  rsp_valid_r <= 1'b0;
                  rsp_data_r  <= '0;
                  rsp_id_r    <= 1'b0;
                  busy_r      <= 1'b0;
                  state_r     <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready = req_ready_s;
   assign bus.sh_string = sh_string_r;
   assign bus.sh_amount = sh_amount_r;
   assign bus.sh_left   = sh_left_r;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_data  = rsp_data_r;
   assign bus.rsp_id    = rsp_id_r;
   assign bus.busy      = busy_r;

endmodule
